// File: rtl/seg_sequencer.sv
// seg_sequencer: power-up sequencer for the balance loop.
//
// Brings the balance loop out of OFF into a soft-start ramp (SOFT), holds it in RUN once the
// ramp completes, and latches an overspeed FAULT after TF_LIMIT consecutive too_fast cycles.
// Every output comes from a register or is decoded from the state register, so no input
// reaches an output within the same cycle.
//
// Parameters:
//   SS_DIV    - clock cycles per ss_tmr increment (1..65535)
//   TF_LIMIT  - consecutive too_fast cycles that trigger a fault (1..255)
//   STEER_DLY - cycles en_steer_req must stay high before en_steer asserts (1..255,
//               used only when SEG_STEER_DELAY_EN is defined)
//
// Build option:
//   SEG_STEER_DELAY_EN - when defined, en_steer is qualified by STEER_DLY consecutive
//                        en_steer_req cycles in RUN; otherwise en_steer follows en_steer_req
//                        in RUN with one cycle of latency.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   pwr_req      in   request to power the balance loop
//   too_fast     in   overspeed flag from the balance math
//   en_steer_req in   steering enable request from rider-weight logic
//   pwr_up       out  motor drive enable (SOFT and RUN)
//   ss_tmr[7:0]  out  soft-start ramp value
//   en_steer     out  steering enable (RUN only)
//   flt          out  overspeed fault latched (FAULT only)

module seg_sequencer #(
    parameter int unsigned SS_DIV    = 16,
    parameter int unsigned TF_LIMIT  = 8,
    parameter int unsigned STEER_DLY = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_req,
    input  logic       too_fast,
    input  logic       en_steer_req,
    output logic       pwr_up,
    output logic [7:0] ss_tmr,
    output logic       en_steer,
    output logic       flt
);

    // Elaboration-time range checks on the configuration.
    if (SS_DIV < 1 || SS_DIV > 65535) begin : g_bad_ss_div
        $error("seg_sequencer: SS_DIV out of range");
    end
    if (TF_LIMIT < 1 || TF_LIMIT > 255) begin : g_bad_tf_limit
        $error("seg_sequencer: TF_LIMIT out of range");
    end
    if (STEER_DLY < 1 || STEER_DLY > 255) begin : g_bad_steer_dly
        $error("seg_sequencer: STEER_DLY out of range");
    end

    typedef enum logic [1:0] {
        StOff,
        StSoft,
        StRun,
        StFault
    } state_e;

    localparam logic [15:0] PreMax = 16'(SS_DIV - 1);
    localparam logic [7:0]  TfMax  = 8'(TF_LIMIT);

    state_e      state_q, state_d;
    logic [15:0] pre_q, pre_d;
    logic [7:0]  ss_q, ss_d;
    logic [7:0]  tf_q, tf_d, tf_inc;
    logic        en_steer_q, en_steer_d;
    logic        active, next_active, pre_wrap, ramp_done, tf_hit;

    always_comb begin
        active    = (state_q == StSoft) || (state_q == StRun);
        // Saturating run length of too_fast while powered.
        tf_inc    = '0;
        if (active && too_fast) begin
            tf_inc = (tf_q >= TfMax) ? TfMax : tf_q + 8'd1;
        end
        tf_hit    = (tf_inc == TfMax);
        pre_wrap  = (pre_q == PreMax);
        ramp_done = (state_q == StSoft) && pre_wrap && (ss_q == 8'hFE);

        // pwr_req=0 is checked first so it wins over a simultaneous fault trigger.
        state_d = state_q;
        unique case (state_q)
            StOff: begin
                if (pwr_req) state_d = StSoft;
            end
            StSoft: begin
                if (!pwr_req)      state_d = StOff;
                else if (tf_hit)   state_d = StFault;
                else if (ramp_done) state_d = StRun;
            end
            StRun: begin
                if (!pwr_req)    state_d = StOff;
                else if (tf_hit) state_d = StFault;
            end
            StFault: begin
                if (!pwr_req) state_d = StOff;
            end
            default: state_d = StOff;
        endcase

        next_active = (state_d == StSoft) || (state_d == StRun);

        // Ramp registers follow the next state so they are already 0 on SOFT entry and on
        // the edge that leaves SOFT/RUN, and already 0xFF on the edge entering RUN.
        pre_d = '0;
        ss_d  = '0;
        case (state_d)
            StSoft: begin
                if (state_q == StSoft) begin
                    pre_d = pre_wrap ? 16'd0 : pre_q + 16'd1;
                    ss_d  = pre_wrap ? ss_q + 8'd1 : ss_q;
                end
            end
            StRun:   ss_d = 8'hFF;
            default: ;
        endcase

        tf_d = next_active ? tf_inc : 8'd0;
    end

`ifdef SEG_STEER_DELAY_EN
    localparam logic [7:0] SteerMax = 8'(STEER_DLY);

    logic [7:0] steer_q, steer_d;

    always_comb begin
        steer_d = '0;
        if ((state_d == StRun) && en_steer_req) begin
            steer_d = (steer_q >= SteerMax) ? SteerMax : steer_q + 8'd1;
        end
        en_steer_d = (steer_d == SteerMax);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            steer_q <= '0;
        end else begin
            steer_q <= steer_d;
        end
    end
`else
    // Using the next state drops en_steer on the very edge that leaves RUN.
    always_comb begin
        en_steer_d = (state_d == StRun) && en_steer_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StOff;
            pre_q      <= '0;
            ss_q       <= '0;
            tf_q       <= '0;
            en_steer_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            ss_q       <= ss_d;
            tf_q       <= tf_d;
            en_steer_q <= en_steer_d;
        end
    end

    assign pwr_up   = (state_q == StSoft) || (state_q == StRun);
    assign flt      = (state_q == StFault);
    assign ss_tmr   = ss_q;
    assign en_steer = en_steer_q;

endmodule

// File: tb/tb_seg_sequencer.sv
// tb_seg_sequencer: self-checking bench for seg_sequencer (SS_DIV=2, TF_LIMIT=4, STEER_DLY=32).
// A behavioural model tracks the mode and cycles spent ramping; a negedge process compares
// every output each cycle, and directed sections add literal expectations.

module tb_seg_sequencer;

    localparam int SS_DIV    = 2;
    localparam int TF_LIMIT  = 4;
    localparam int STEER_DLY = 32;

    localparam int MOff   = 0;
    localparam int MSoft  = 1;
    localparam int MRun   = 2;
    localparam int MFault = 3;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       pwr_req      = 1'b1;
    logic       too_fast     = 1'b1;
    logic       en_steer_req = 1'b0;
    logic       pwr_up;
    logic [7:0] ss_tmr;
    logic       en_steer;
    logic       flt;

    int n_checks = 0;
    int n_fail   = 0;

    seg_sequencer #(
        .SS_DIV   (SS_DIV),
        .TF_LIMIT (TF_LIMIT),
        .STEER_DLY(STEER_DLY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwr_req     (pwr_req),
        .too_fast    (too_fast),
        .en_steer_req(en_steer_req),
        .pwr_up      (pwr_up),
        .ss_tmr      (ss_tmr),
        .en_steer    (en_steer),
        .flt         (flt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int mode;
        int elapsed;  // cycles since SOFT entry
        int tf;       // consecutive too_fast cycles while powered
        int steer;    // consecutive en_steer_req cycles in RUN
        bit en;
        bit known;
    } model_t;

    model_t mdl = '0;

    function automatic model_t model_step(model_t m, logic rst, logic pwr, logic fast,
                                          logic sreq);
        model_t n;
        int     tfn;
        bit     live;
        n = m;
        if (rst !== 1'b1) begin
            n       = '0;
            n.mode  = MOff;
            n.known = 1'b1;
            return n;
        end
        live = (m.mode == MSoft) || (m.mode == MRun);
        tfn  = (live && fast) ? ((m.tf < TF_LIMIT) ? m.tf + 1 : TF_LIMIT) : 0;
        case (m.mode)
            MOff: begin
                n.mode    = pwr ? MSoft : MOff;
                n.elapsed = 0;
            end
            MSoft, MRun: begin
                if (!pwr) n.mode = MOff;
                else if (tfn == TF_LIMIT) n.mode = MFault;
                else if (m.mode == MSoft) begin
                    n.elapsed = m.elapsed + 1;
                    if (n.elapsed == 255 * SS_DIV) n.mode = MRun;
                end
            end
            default: n.mode = pwr ? MFault : MOff;
        endcase
        if (n.mode != MSoft) n.elapsed = 0;
        n.tf = ((n.mode == MSoft) || (n.mode == MRun)) ? tfn : 0;
`ifdef SEG_STEER_DELAY_EN
        n.steer = ((n.mode == MRun) && sreq) ? ((m.steer < STEER_DLY) ? m.steer + 1 : STEER_DLY)
                                             : 0;
        n.en    = (n.steer == STEER_DLY);
`else
        n.steer = 0;
        n.en    = (n.mode == MRun) && sreq;
`endif
        return n;
    endfunction

    function automatic logic [7:0] model_ss(model_t m);
        if (m.mode == MSoft) return 8'(m.elapsed / SS_DIV);
        if (m.mode == MRun) return 8'hFF;
        return 8'h00;
    endfunction

    always @(posedge clk) mdl <= model_step(mdl, rst_n, pwr_req, too_fast, en_steer_req);

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%02h, expected 0x%02h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mdl.known) begin
            chk("model_pwr_up", {7'd0, pwr_up},
                {7'd0, (mdl.mode == MSoft) || (mdl.mode == MRun)});
            chk("model_ss_tmr", ss_tmr, model_ss(mdl));
            chk("model_en_steer", {7'd0, en_steer}, {7'd0, mdl.en});
            chk("model_flt", {7'd0, flt}, {7'd0, mdl.mode == MFault});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int burst;
        int len;

        // Reset with pwr_req and too_fast high.
        tick(2);
        chk("rst_pwr_up", {7'd0, pwr_up}, 8'd0);
        chk("rst_ss_tmr", ss_tmr, 8'h00);
        chk("rst_en_steer", {7'd0, en_steer}, 8'd0);
        chk("rst_flt", {7'd0, flt}, 8'd0);

        // Ramp to RUN.
        rst_n    = 1'b1;
        too_fast = 1'b0;
        tick(1);
        chk("ramp_pwr_up", {7'd0, pwr_up}, 8'd1);
        chk("ramp_entry_ss", ss_tmr, 8'h00);
        tick(2);
        chk("ramp_ss_01", ss_tmr, 8'h01);
        tick(507);
        chk("ramp_ss_fe", ss_tmr, 8'hFE);
        tick(1);
        chk("ramp_ss_ff", ss_tmr, 8'hFF);
        chk("ramp_model_run", 8'(mdl.mode), 8'(MRun));
        tick(100);
        chk("ramp_ss_hold", ss_tmr, 8'hFF);

        // Steering in RUN.
        en_steer_req = 1'b1;
`ifdef SEG_STEER_DELAY_EN
        tick(31);
        chk("steer_early", {7'd0, en_steer}, 8'd0);
        tick(1);
        chk("steer_on", {7'd0, en_steer}, 8'd1);
        en_steer_req = 1'b0;
        tick(1);
        chk("steer_pulse_off", {7'd0, en_steer}, 8'd0);
        en_steer_req = 1'b1;
        tick(31);
        chk("steer_restart_early", {7'd0, en_steer}, 8'd0);
        tick(1);
        chk("steer_restart_on", {7'd0, en_steer}, 8'd1);
`else
        tick(1);
        chk("steer_on", {7'd0, en_steer}, 8'd1);
        en_steer_req = 1'b0;
        tick(1);
        chk("steer_pulse_off", {7'd0, en_steer}, 8'd0);
        en_steer_req = 1'b1;
        tick(1);
        chk("steer_restart_on", {7'd0, en_steer}, 8'd1);
`endif

        // Overspeed: three cycles is tolerated, four faults.
        too_fast = 1'b1;
        tick(3);
        too_fast = 1'b0;
        tick(1);
        chk("tf3_no_flt", {7'd0, flt}, 8'd0);
        too_fast = 1'b1;
        tick(3);
        chk("tf3b_pwr_up", {7'd0, pwr_up}, 8'd1);
        tick(1);
        chk("tf4_flt", {7'd0, flt}, 8'd1);
        chk("tf4_pwr_up", {7'd0, pwr_up}, 8'd0);
        chk("tf4_ss_tmr", ss_tmr, 8'h00);
        chk("tf4_en_steer", {7'd0, en_steer}, 8'd0);
        too_fast = 1'b0;
        tick(5);
        chk("flt_held", {7'd0, flt}, 8'd1);
        pwr_req = 1'b0;
        tick(1);
        chk("flt_clear", {7'd0, flt}, 8'd0);
        chk("flt_clear_pwr", {7'd0, pwr_up}, 8'd0);

        // Abort mid-ramp and restart.
        pwr_req = 1'b1;
        tick(129);
        chk("abort_ss_40", ss_tmr, 8'h40);
        pwr_req = 1'b0;
        tick(1);
        chk("abort_pwr_up", {7'd0, pwr_up}, 8'd0);
        chk("abort_ss", ss_tmr, 8'h00);
        pwr_req = 1'b1;
        tick(1);
        chk("restart_ss", ss_tmr, 8'h00);
        tick(2);
        chk("restart_ss_01", ss_tmr, 8'h01);

        // pwr_req=0 beats the fourth too_fast.
        too_fast = 1'b1;
        tick(3);
        pwr_req = 1'b0;
        tick(1);
        chk("prio_flt", {7'd0, flt}, 8'd0);
        chk("prio_pwr_up", {7'd0, pwr_up}, 8'd0);
        too_fast = 1'b0;

        // Reset mid-ramp.
        pwr_req = 1'b1;
        tick(50);
        chk("mid_ss", ss_tmr, 8'd24);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_pwr", {7'd0, pwr_up}, 8'd0);
        chk("mid_rst_ss", ss_tmr, 8'h00);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_pwr", {7'd0, pwr_up}, 8'd1);
        tick(2);
        chk("post_rst_ss", ss_tmr, 8'h01);

        // Randomised episodes.
        burst = 0;
        for (int ep = 0; ep < 8; ep++) begin
            len     = $urandom_range(300, 900);
            pwr_req = 1'b1;
            for (int c = 0; c < len; c++) begin
                if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(1, 5);
                too_fast = (burst > 0);
                if (burst > 0) burst--;
                if ($urandom_range(0, 7) == 0) en_steer_req = ~en_steer_req;
                rst_n = ($urandom_range(0, 999) != 0);
                tick(1);
            end
            rst_n    = 1'b1;
            pwr_req  = 1'b0;
            too_fast = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_sequencer.md
SEG_SEQUENCER -- requirements
Module: seg_sequencer

Interface
REQ-001 SHALL have parameter SS_DIV, default 16, clock cycles per ss_tmr increment (legal range 1..65535).
REQ-002 SHALL have parameter TF_LIMIT, default 8, consecutive too_fast cycles that trigger a fault (legal range 1..255).
REQ-003 SHALL have parameter STEER_DLY, default 32, cycles en_steer_req must stay high before en_steer asserts (macro build only; legal range 1..255).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port pwr_req, input, 1, rider/authorization request to power the balance loop.
REQ-007 SHALL have port too_fast, input, 1, overspeed flag from the balance math.
REQ-008 SHALL have port en_steer_req, input, 1, steering enable request from rider-weight logic.
REQ-009 SHALL have port pwr_up, output, 1, enables motor drive in the balance math.
REQ-010 SHALL have port ss_tmr, output, 8, soft-start ramp value to the balance math.
REQ-011 SHALL have port en_steer, output, 1, steering enable to the balance math.
REQ-012 SHALL have port flt, output, 1, overspeed fault latched.

Function
REQ-013 SHALL implement FSM states OFF, SOFT, RUN and FAULT; all outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output path.
REQ-014 SHALL drive pwr_up=1 in SOFT and RUN only, and flt=1 in FAULT only.
REQ-015 OFF->SOFT SHALL occur on the edge sampling pwr_req=1, so pwr_up rises 1 cycle after pwr_req.
REQ-016 In SOFT, a prescaler SHALL count 0..SS_DIV-1 and increment ss_tmr by 1 on wrap; ss_tmr SHALL be 0x00 on SOFT entry.
REQ-017 SOFT->RUN SHALL occur on the same edge ss_tmr goes 0xFE->0xFF, i.e. 255*SS_DIV cycles after SOFT entry; ss_tmr SHALL hold 0xFF in RUN and never wrap.
REQ-018 In OFF and FAULT, ss_tmr and the prescaler SHALL be 0.
REQ-019 SOFT or RUN ->OFF SHALL occur on the edge sampling pwr_req=0.
REQ-020 A saturating counter SHALL count consecutive too_fast=1 cycles in SOFT/RUN and clear when too_fast=0 or in any other state.
REQ-021 SOFT or RUN ->FAULT SHALL occur on the edge where the counter reaches TF_LIMIT.
REQ-022 FAULT SHALL be held while pwr_req=1; FAULT->OFF SHALL occur on the edge sampling pwr_req=0.
REQ-023 When pwr_req=0 and a fault trigger occur on the same edge, pwr_req=0 SHALL take priority (next state OFF, flt=0).
REQ-024 en_steer SHALL be 0 in every state except RUN and SHALL drop on the edge that leaves RUN.

Reset
REQ-025 On the edge sampling rst_n=0, the block SHALL go to OFF with pwr_up=0, ss_tmr=0x00, en_steer=0, flt=0 and all counters cleared, regardless of other inputs.
REQ-026 After release, the block SHALL re-enter SOFT only on a subsequent edge sampling pwr_req=1; a reset mid-ramp SHALL restart ss_tmr from 0x00.

Configuration
REQ-027 Macro SEG_STEER_DELAY_EN SHALL control steering qualification.
REQ-028 Without the macro, en_steer SHALL be registered as (state==RUN && en_steer_req), giving 1-cycle latency.
REQ-029 With the macro, a counter SHALL count consecutive en_steer_req=1 cycles in RUN; en_steer SHALL assert when the count reaches STEER_DLY, and the counter and en_steer SHALL clear on the next edge after en_steer_req=0 or on leaving RUN.

Verification (SS_DIV=2, TF_LIMIT=4, STEER_DLY=32)
REQ-030 Reset: rst_n=0 for 2 cycles with pwr_req=1 and too_fast=1 -> pwr_up=0, ss_tmr=0x00, en_steer=0, flt=0.
REQ-031 Ramp: pwr_req=1 -> pwr_up=1 after 1 cycle; ss_tmr=0x01 2 cycles later; ss_tmr=0xFF and state RUN 510 cycles after SOFT entry; ss_tmr holds 0xFF for 100 more cycles.
REQ-032 Fault: 3 too_fast cycles then low -> no fault; 4 consecutive -> flt=1, pwr_up=0, ss_tmr=0x00 on the next edge; state held until pwr_req=0, then OFF with flt=0.
REQ-033 Abort: pwr_req=0 at ss_tmr=0x40 -> OFF and ss_tmr=0x00 next cycle; pwr_req=1 again -> ramp restarts at 0x00.
REQ-034 Steer in RUN: en_steer_req=1 -> en_steer=1 after 1 cycle (no macro) or after 32 cycles (macro); a 1-cycle low pulse on en_steer_req clears en_steer and, with the macro, restarts the 32-cycle count.
REQ-035 Priority: pwr_req=0 on the same edge as the 4th consecutive too_fast -> state OFF, flt=0.
